uart_cmd_loader: RTL and testbench
==================================

// Module: uart_cmd_loader
// PURPOSE
//  Receive-side counterpart of the MxV result transmitter. Parses framed host
//  commands from the UART receiver (byte + interrupt), then drives the MxV
//  inputs: matrix_length, vector, FIFO push of matrix elements, stretched start.
//  Frame: SOF, CMD, LEN, LEN payload bytes, EOF. Runs on the FPGA clock;
//  start is stretched so the divided MxV clock samples it.
// PARAMETERS
//  WORD_LENGTH   8       FIFO word width; >=8; byte zero-extended into LSBs
//  MAX_N         8       max matrix dimension; <=8 (vector is 8 x 8 bits)
//  START_CYCLES  10000   start pulse width in clk cycles (50 MHz / 5 kHz)
//  SOF           8'hFE   start-of-frame byte
//  EOF           8'hEF   end-of-frame byte
// PORTS
//  clk             in   1            FPGA clock
//  reset           in   1            async, active-high
//  rx_data         in   8            UART ReceivedData
//  rx_valid        in   1            UART RxInterrupt (level, held until cleared)
//  rx_parity_err   in   1            UART ParityError, valid with rx_valid
//  clear_interrupt out  1            UART ClearInterrupt, 1-cycle pulse
//  matrix_length   out  32           committed N, zero-extended
//  vector          out  64           committed vector, element i at [8i+:8]
//  fifo_value      out  WORD_LENGTH  matrix element to FIFO
//  fifo_push       out  1            1-cycle push strobe
//  start           out  1            MxV start, START_CYCLES wide
//  frame_error     out  1            1-cycle error strobe
// BEHAVIOUR
//  Reset: all outputs 0; state HUNT; counters and staging regs 0.
//  Byte accept: rx_valid=1 and clear_interrupt=0. Next cycle: clear_interrupt=1
//   (suppresses re-accept of the held interrupt). One byte per 2 clks max.
//  Parity error on any accepted byte: discard byte, frame_error, state -> HUNT.
//  FSM (transitions on accepted bytes):
//   HUNT: SOF -> CMD; other bytes ignored, no error.
//   CMD: 01 size, 02 start, 03 matrix, 04 vector -> LEN; other -> error, HUNT.
//   LEN: must equal 1 (01), 0 (02), N*N (03), N (04), N = committed length.
//    03/04/02 with N=0 -> error. Mismatch -> error, HUNT. LEN=0 -> TRAIL,
//    else DATA with byte counter cleared.
//   DATA: 01: stage byte; 04: byte k -> staged vector[8k+:8] (unsent bytes 0);
//    03: fifo_value<=byte, fifo_push=1 the cycle after accept (same cycle as
//    clear_interrupt). Last byte (count=LEN-1) -> TRAIL.
//   TRAIL: EOF -> commit, HUNT. Other byte -> error, discard staged data, HUNT.
//    That byte is not re-examined as SOF.
//  Commit (outputs update cycle after EOF accept):
//   01: payload in 1..MAX_N -> matrix_length; else error, length unchanged.
//   04: vector <= staged vector.   03: nothing; elements already pushed.
//   02: start=1 for exactly START_CYCLES clks. A start commit while start is
//    high reloads the counter (pulse extends); no error.
//  Matrix bytes pushed before a bad EOF stay in the FIFO; the host resends.
//  frame_error: 1-cycle pulse, cycle after the offending byte is accepted.
//  Reset mid-frame or mid-start: immediate return to reset values. start
//   drops and matrix_length/vector clear.
// TESTING
//  1 FE 01 01 04 EF -> matrix_length=4, 5 clear_interrupt pulses, no error.
//  2 after 1: FE 04 04 11 22 33 44 EF -> vector=64'h0000_0000_4433_2211.
//  3 N=2: FE 03 04 01 02 03 04 EF -> 4 fifo_push pulses, values 01,02,03,04.
//  4 FE 02 00 EF -> start high exactly 10000 clks, starting cycle after EF.
//  5 N=4: FE 01 02 .. -> error at LEN; 55 FE 01 01 09 EF -> error at commit
//    (9>MAX_N), matrix_length stays 4; FE 01 01 03 EF -> length=3.
//  6 Parity error on 2nd vector byte -> error, vector unchanged; reset
//    mid-start -> start=0, all outputs 0, next valid frame parsed.

Source files
------------

// File: rtl/uart_cmd_loader_if.sv
// Bundle of the UART receiver handshake and the MxV-facing outputs of
// uart_cmd_loader.
//   master : drives the UART byte/interrupt side and observes the loader outputs
//            (UART receiver model or testbench)
//   slave  : the command loader itself
// Signals
//   rx_data         UART ReceivedData
//   rx_valid        UART RxInterrupt, a level held until clear_interrupt
//   rx_parity_err   UART ParityError, valid with rx_valid
//   clear_interrupt UART ClearInterrupt, 1-cycle pulse
//   matrix_length   committed N, zero-extended
//   vector          committed vector, element i at [8i+:8]
//   fifo_value      matrix element for the FIFO
//   fifo_push       1-cycle push strobe
//   start           MxV start, stretched
//   frame_error     1-cycle error strobe
interface uart_cmd_loader_if #(
  parameter int WORD_LENGTH = 8
);
  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic                   rx_parity_err;
  logic                   clear_interrupt;
  logic [31:0]            matrix_length;
  logic [63:0]            vector;
  logic [WORD_LENGTH-1:0] fifo_value;
  logic                   fifo_push;
  logic                   start;
  logic                   frame_error;

  modport master (
    output rx_data, rx_valid, rx_parity_err,
    input  clear_interrupt, matrix_length, vector, fifo_value, fifo_push,
           start, frame_error
  );

  modport slave (
    input  rx_data, rx_valid, rx_parity_err,
    output clear_interrupt, matrix_length, vector, fifo_value, fifo_push,
           start, frame_error
  );
endinterface

// File: rtl/uart_cmd_loader.sv
// uart_cmd_loader
// Parses framed host commands arriving byte by byte from a UART receiver and
// drives the MxV inputs. Frame layout: SOF, CMD, LEN, LEN payload bytes, EOF.
//   01 size   : one byte N in 1..MAX_N, becomes matrix_length on commit
//   02 start  : no payload, stretches start for START_CYCLES clocks on commit
//   03 matrix : N*N elements, each pushed to the FIFO as it arrives
//   04 vector : N bytes, staged and copied to vector on commit
// Ports
//   clk    FPGA clock
//   reset  asynchronous, active-high
//   bus    uart_cmd_loader_if.slave (UART handshake in, MxV outputs)
module uart_cmd_loader #(
  parameter int         WORD_LENGTH  = 8,
  parameter int         MAX_N        = 8,
  parameter int         START_CYCLES = 10000,
  parameter logic [7:0] SOF          = 8'hFE,
  parameter logic [7:0] EOF          = 8'hEF
) (
  input  logic            clk,
  input  logic            reset,
  uart_cmd_loader_if.slave bus
);

  typedef enum logic [2:0] {HUNT, CMD, LEN, DATA, TRAIL} state_e;

  localparam logic [7:0] CMD_SIZE   = 8'h01;
  localparam logic [7:0] CMD_START  = 8'h02;
  localparam logic [7:0] CMD_MATRIX = 8'h03;
  localparam logic [7:0] CMD_VECTOR = 8'h04;

  localparam int CW = $clog2(START_CYCLES + 1);

  state_e          state_q, state_d;
  logic [7:0]      cmd_q;
  logic [7:0]      len_q;
  logic [7:0]      cnt_q;
  logic [7:0]      stage_len_q;
  logic [63:0]     stage_vec_q;
  logic [7:0]      n_q;
  logic [63:0]     vec_q;
  logic [CW-1:0]   start_cnt_q;

  logic            accept;
  logic [7:0]      exp_len;
  logic            len_ok;
  logic            err_d, push_d;
  logic            take_cmd, take_len, take_data;
  logic            commit_len, commit_vec, commit_start;

  // The interrupt stays high until cleared; the cycle clear_interrupt is high
  // must not count as a second byte.
  assign accept = bus.rx_valid && !bus.clear_interrupt;

  assign bus.matrix_length = {24'd0, n_q};
  assign bus.vector        = vec_q;

  // Required LEN for the command captured in CMD; N comes from the committed
  // length, so N*N never exceeds 64 and fits the byte.
  always_comb begin
    exp_len = 8'd0;
    case (cmd_q)
      CMD_SIZE:   exp_len = 8'd1;
      CMD_START:  exp_len = 8'd0;
      CMD_MATRIX: exp_len = 8'(n_q * n_q);
      CMD_VECTOR: exp_len = n_q;
      default:    exp_len = 8'd0;
    endcase
  end

  // Every command except size needs a committed N first.
  assign len_ok = (bus.rx_data == exp_len) && ((cmd_q == CMD_SIZE) || (n_q != 8'd0));

  // NOTE: every output of this block gets a default before the case, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    err_d        = 1'b0;
    push_d       = 1'b0;
    take_cmd     = 1'b0;
    take_len     = 1'b0;
    take_data    = 1'b0;
    commit_len   = 1'b0;
    commit_vec   = 1'b0;
    commit_start = 1'b0;
    if (accept) begin
      if (bus.rx_parity_err) begin
        err_d   = 1'b1;
        state_d = HUNT;
      end else begin
        case (state_q)
          HUNT: if (bus.rx_data == SOF) state_d = CMD;
          CMD: begin
            if (bus.rx_data >= CMD_SIZE && bus.rx_data <= CMD_VECTOR) begin
              take_cmd = 1'b1;
              state_d  = LEN;
            end else begin
              err_d   = 1'b1;
              state_d = HUNT;
            end
          end
          LEN: begin
            if (len_ok) begin
              take_len = 1'b1;
              state_d  = (bus.rx_data == 8'd0) ? TRAIL : DATA;
            end else begin
              err_d   = 1'b1;
              state_d = HUNT;
            end
          end
          DATA: begin
            take_data = 1'b1;
            push_d    = (cmd_q == CMD_MATRIX);
            if (cnt_q == len_q - 8'd1) state_d = TRAIL;
          end
          TRAIL: begin
            // A wrong trailer byte is consumed by the error; it is never
            // re-examined as a possible SOF.
            state_d = HUNT;
            if (bus.rx_data == EOF) begin
              case (cmd_q)
                CMD_SIZE: begin
                  if (stage_len_q != 8'd0 && stage_len_q <= 8'(MAX_N)) commit_len = 1'b1;
                  else err_d = 1'b1;
                end
                CMD_VECTOR: commit_vec   = 1'b1;
                CMD_START:  commit_start = 1'b1;
                default:    ;
              endcase
            end else begin
              err_d = 1'b1;
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= HUNT;
    else       state_q <= state_d;
  end

  // Staging registers are plain flops, not a RAM, so they are cleared by reset
  // along with everything else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q               <= 8'd0;
      len_q               <= 8'd0;
      cnt_q               <= 8'd0;
      stage_len_q         <= 8'd0;
      stage_vec_q         <= 64'd0;
      n_q                 <= 8'd0;
      vec_q               <= 64'd0;
      start_cnt_q         <= '0;
      bus.clear_interrupt <= 1'b0;
      bus.frame_error     <= 1'b0;
      bus.fifo_push       <= 1'b0;
      bus.fifo_value      <= '0;
      bus.start           <= 1'b0;
    end else begin
      bus.clear_interrupt <= accept;
      bus.frame_error     <= err_d;
      bus.fifo_push       <= push_d;
      if (push_d) bus.fifo_value <= WORD_LENGTH'(bus.rx_data);

      if (take_cmd) cmd_q <= bus.rx_data;

      // Unsent vector bytes must read back as zero, so staging is cleared at
      // the start of every payload.
      if (take_len) begin
        len_q       <= bus.rx_data;
        cnt_q       <= 8'd0;
        stage_len_q <= 8'd0;
        stage_vec_q <= 64'd0;
      end

      if (take_data) begin
        cnt_q <= cnt_q + 8'd1;
        if (cmd_q == CMD_SIZE)   stage_len_q <= bus.rx_data;
        if (cmd_q == CMD_VECTOR) stage_vec_q[{cnt_q[2:0], 3'b000} +: 8] <= bus.rx_data;
      end

      if (commit_len) n_q   <= stage_len_q;
      if (commit_vec) vec_q <= stage_vec_q;

      // The counter holds the cycles still to go after the current one; a new
      // start commit simply reloads it, extending the pulse.
      if (commit_start) begin
        bus.start   <= 1'b1;
        start_cnt_q <= CW'(START_CYCLES - 1);
      end else if (bus.start) begin
        if (start_cnt_q == '0) bus.start   <= 1'b0;
        else                   start_cnt_q <= start_cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_loader.sv
module tb_uart_cmd_loader;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic reset;

  uart_cmd_loader_if #(.WORD_LENGTH(8)) bus ();

  uart_cmd_loader #(
    .WORD_LENGTH (8),
    .MAX_N       (8),
    .START_CYCLES(10000),
    .SOF         (8'hFE),
    .EOF         (8'hEF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int ci_cnt = 0;
  int fe_cnt = 0;
  int st_cnt = 0;
  int push_cnt = 0;
  logic start_at_ack = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Output monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.clear_interrupt) ci_cnt++;
    if (bus.frame_error)     fe_cnt++;
    if (bus.start)           st_cnt++;
    if (bus.fifo_push) begin
      push_cnt++;
      if (exp_q.size() == 0) check("push_with_empty_scoreboard", 64'(exp_q.size()), 64'd1);
      else                   check("fifo_value", 64'(bus.fifo_value), 64'(exp_q.pop_front()));
    end
  end

  // UART model: hold the interrupt until the loader clears it.
  task automatic send_byte(input logic [7:0] b, input logic par);
    logic got;
    got = 1'b0;
    bus.rx_data       = b;
    bus.rx_valid      = 1'b1;
    bus.rx_parity_err = par;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (bus.clear_interrupt) begin
        got          = 1'b1;
        start_at_ack = bus.start;
      end
    end
    check("clear_interrupt_ack", 64'(got), 64'd1);
    bus.rx_valid      = 1'b0;
    bus.rx_parity_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input byte_q_t fr);
    foreach (fr[i]) send_byte(fr[i], 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t fr;
    int ci0, fe0, p0;

    reset = 1'b1;
    bus.rx_data = 8'd0;
    bus.rx_valid = 1'b0;
    bus.rx_parity_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_matrix_length",   64'(bus.matrix_length),   64'd0);
    check("rst_vector",          bus.vector,               64'd0);
    check("rst_start",           64'(bus.start),           64'd0);
    check("rst_fifo_push",       64'(bus.fifo_push),       64'd0);
    check("rst_frame_error",     64'(bus.frame_error),     64'd0);
    check("rst_clear_interrupt", 64'(bus.clear_interrupt), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: size command
    ci0 = ci_cnt; fe0 = fe_cnt;
    fr = '{8'hFE, 8'h01, 8'h01, 8'h04, 8'hEF};
    send_frame(fr);
    check("t1_length",   64'(bus.matrix_length), 64'd4);
    check("t1_ci_count", 64'(ci_cnt - ci0),      64'd5);
    check("t1_no_error", 64'(fe_cnt - fe0),      64'd0);

    // 2: vector command
    fr = '{8'hFE, 8'h04, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hEF};
    send_frame(fr);
    check("t2_vector", bus.vector, 64'h0000_0000_4433_2211);

    // 3: N=2 then a 2x2 matrix
    fr = '{8'hFE, 8'h01, 8'h01, 8'h02, 8'hEF};
    send_frame(fr);
    check("t3_length", 64'(bus.matrix_length), 64'd2);
    p0 = push_cnt;
    for (int k = 1; k <= 4; k++) exp_q.push_back(8'(k));
    fr = '{8'hFE, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hEF};
    send_frame(fr);
    check("t3_push_count",     64'(push_cnt - p0),  64'd4);
    check("t3_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // 4: start pulse width
    st_cnt = 0;
    fr = '{8'hFE, 8'h02, 8'h00};
    send_frame(fr);
    check("t4_start_before_eof", 64'(bus.start), 64'd0);
    send_byte(8'hEF, 1'b0);
    check("t4_start_cycle_after_eof", 64'(start_at_ack), 64'd1);
    for (int i = 0; i < 10100 && bus.start; i++) @(negedge clk);
    check("t4_start_dropped", 64'(bus.start), 64'd0);
    check("t4_start_width",   64'(st_cnt),    64'd10000);

    // 5: length errors
    fr = '{8'hFE, 8'h01, 8'h01, 8'h04, 8'hEF};
    send_frame(fr);
    fe0 = fe_cnt;
    fr = '{8'hFE, 8'h01, 8'h02};
    send_frame(fr);
    check("t5_len_error", 64'(fe_cnt - fe0), 64'd1);
    fe0 = fe_cnt;
    fr = '{8'h55, 8'hFE, 8'h01, 8'h01, 8'h09, 8'hEF};
    send_frame(fr);
    check("t5_commit_error", 64'(fe_cnt - fe0),      64'd1);
    check("t5_length_kept",  64'(bus.matrix_length), 64'd4);
    fe0 = fe_cnt;
    fr = '{8'hFE, 8'h01, 8'h01, 8'h03, 8'hEF};
    send_frame(fr);
    check("t5_length_3",  64'(bus.matrix_length), 64'd3);
    check("t5_no_error",  64'(fe_cnt - fe0),      64'd0);

    // 6: parity error mid-vector, bad trailer, then a short good vector
    fe0 = fe_cnt;
    fr = '{8'hFE, 8'h04, 8'h03, 8'hAA};
    send_frame(fr);
    send_byte(8'hBB, 1'b1);
    fr = '{8'hCC, 8'hEF};
    send_frame(fr);
    check("t6_parity_error", 64'(fe_cnt - fe0), 64'd1);
    check("t6_vector_kept",  bus.vector,        64'h0000_0000_4433_2211);
    fe0 = fe_cnt;
    fr = '{8'hFE, 8'h04, 8'h03, 8'h01, 8'h02, 8'h03, 8'h00};
    send_frame(fr);
    check("t6_trailer_error",   64'(fe_cnt - fe0), 64'd1);
    check("t6_vector_kept2",    bus.vector,        64'h0000_0000_4433_2211);
    fr = '{8'hFE, 8'h04, 8'h03, 8'h01, 8'h02, 8'h03, 8'hEF};
    send_frame(fr);
    check("t6_vector_short", bus.vector, 64'h0000_0000_0003_0201);

    // Reset during a start pulse
    fr = '{8'hFE, 8'h02, 8'h00, 8'hEF};
    send_frame(fr);
    check("t7_start_high", 64'(bus.start), 64'd1);
    repeat (50) @(negedge clk);
    reset = 1'b1;
    #1;
    check("t7_rst_start",  64'(bus.start),         64'd0);
    check("t7_rst_length", 64'(bus.matrix_length), 64'd0);
    check("t7_rst_vector", bus.vector,             64'd0);
    check("t7_rst_error",  64'(bus.frame_error),   64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    fr = '{8'hFE, 8'h01, 8'h01, 8'h05, 8'hEF};
    send_frame(fr);
    check("t7_after_reset_length", 64'(bus.matrix_length), 64'd5);
    check("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
